stream_pkt_fifo: RTL and testbench

- Per-master-port elastic buffer that sits directly downstream of stream_xbar; one instance per m_* output.
- Accepts the crossbar's output stream (data, source id, last) and re-presents it to the consumer with full valid/ready decoupling.
- Absorbs consumer back-pressure so the crossbar's arbitration is not stalled cycle by cycle.
- Optional store-and-forward mode releases only complete packets.

---
 rtl/stream_pkg.sv | 27 ++
 rtl/stream_fifo_mem.sv | 21 ++
 rtl/stream_pkt_fifo.sv | 88 ++++++++
 tb/tb_stream_pkt_fifo.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared widths, pointer sizing and beat packing for stream blocks
package stream_pkg;
  localparam int T_DATA_WIDTH_DEF = 8;
  localparam int T_ID_WIDTH_DEF   = 1;
  localparam int MAX_DATA_W       = 64;
  localparam int MAX_ID_W         = 16;
  localparam int MAX_BEAT_W       = MAX_DATA_W + MAX_ID_W + 1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Packs {last, id, data} LSB-aligned; callers cast down to their own beat width.
  function automatic logic [MAX_BEAT_W-1:0] pack_beat(
    input logic                  last,
    input logic [MAX_ID_W-1:0]   id,
    input logic [MAX_DATA_W-1:0] data,
    input int                    data_w,
    input int                    id_w
  );
    logic [MAX_BEAT_W-1:0] b;
    b = MAX_BEAT_W'(data)
      | (MAX_BEAT_W'(id) << data_w)
      | (MAX_BEAT_W'(last) << (data_w + id_w));
    return b;
  endfunction
endpackage

// File: rtl/stream_fifo_mem.sv
// rtl/stream_fifo_mem.sv - register array, one write port, one asynchronous read port
module stream_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/stream_pkt_fifo.sv
// rtl/stream_pkt_fifo.sv - first-word fall-through packet FIFO behind stream_xbar
// STREAM_PKT_FIFO_STORE_FWD_EN enables store-and-forward release of whole packets.
module stream_pkt_fifo
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = T_DATA_WIDTH_DEF,
  parameter int T_ID_WIDTH   = T_ID_WIDTH_DEF,
  parameter int DEPTH        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [T_DATA_WIDTH-1:0]  s_data_i,
  input  logic [T_ID_WIDTH-1:0]    s_id_i,
  input  logic                     s_last_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [T_DATA_WIDTH-1:0]  m_data_o,
  output logic [T_ID_WIDTH-1:0]    m_id_o,
  output logic                     m_last_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int AW     = PTR_W - 1;
  localparam int BEAT_W = T_DATA_WIDTH + T_ID_WIDTH + 1;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [BEAT_W-1:0] wdata, rdata;
  logic              empty, full, wr_en, rd_en;

  assign wdata = BEAT_W'(pack_beat(s_last_i, MAX_ID_W'(s_id_i), MAX_DATA_W'(s_data_i),
                                   T_DATA_WIDTH, T_ID_WIDTH));

  stream_fifo_mem #(.WIDTH(BEAT_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  assign m_data_o = rdata[T_DATA_WIDTH-1:0];
  assign m_id_o   = rdata[T_DATA_WIDTH +: T_ID_WIDTH];
  assign m_last_o = rdata[BEAT_W-1];

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign s_ready_o = !full;
  assign wr_en     = s_valid_i && !full;
  assign rd_en     = m_valid_o && m_ready_i;
  assign count_o   = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

`ifdef STREAM_PKT_FIFO_STORE_FWD_EN
  logic [PTR_W-1:0] pkt_cnt;
  logic             mid_pkt;

  // mid_pkt keeps a packet flowing once its first beat has left (full-buffer escape).
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
      mid_pkt <= 1'b0;
    end else begin
      case ({wr_en && s_last_i, rd_en && m_last_o})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_W'(1);
        2'b01:   pkt_cnt <= pkt_cnt - PTR_W'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
      if (rd_en) mid_pkt <= !m_last_o;
    end
  end

  assign m_valid_o = !empty && ((pkt_cnt != '0) || full || mid_pkt);
`else
  assign m_valid_o = !empty;
`endif
endmodule

// File: tb/tb_stream_pkt_fifo.sv
// tb/tb_stream_pkt_fifo.sv - randomized and directed checks of stream_pkt_fifo against a queue model
module tb_stream_pkt_fifo;
  localparam int DW    = 4;
  localparam int IW    = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [IW-1:0] s_id = '0;
  logic          s_last = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_id;
  logic          m_last;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [2:0]    count;

  stream_pkt_fifo #(.T_DATA_WIDTH(DW), .T_ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (s_data),
    .s_id_i    (s_id),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_id_o    (m_id),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .count_o   (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } beat_t;

  beat_t q[$];
  bit    mid = 1'b0;
  int    total = 0;
  int    bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Head visible when anything is queued; store-and-forward additionally needs a
  // complete packet, a full buffer, or a packet already partly delivered.
  function automatic bit exp_valid();
    if (q.size() == 0) return 1'b0;
`ifdef STREAM_PKT_FIFO_STORE_FWD_EN
    begin
      int n = 0;
      foreach (q[i]) if (q[i].last) n++;
      return (n != 0) || (q.size() == DEPTH) || mid;
    end
`else
    return 1'b1;
`endif
  endfunction

  task automatic cyc(input logic sv, input logic [DW-1:0] d, input logic [IW-1:0] id,
                     input logic last, input logic mr);
    bit wr, rd;
    @(negedge clk);
    rst = 1'b0;
    check("count", 32'(count), 32'(q.size()));
    check("s_ready", 32'(s_ready), 32'(q.size() < DEPTH));
    check("m_valid", 32'(m_valid), 32'(exp_valid()));
    if (exp_valid()) begin
      check("m_data", 32'(m_data), 32'(q[0].data));
      check("m_id", 32'(m_id), 32'(q[0].id));
      check("m_last", 32'(m_last), 32'(q[0].last));
    end
    s_valid = sv;
    s_data  = d;
    s_id    = id;
    s_last  = last;
    m_ready = mr;
    wr = sv && (q.size() < DEPTH);
    rd = exp_valid() && mr;
    @(posedge clk);
    if (rd) begin
      mid = !q[0].last;
      void'(q.pop_front());
    end
    if (wr) q.push_back('{last: last, id: id, data: d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(posedge clk);
    q.delete();
    mid = 1'b0;
  endtask

  initial begin
    do_reset();
    cyc(0, 4'h0, 1'b0, 1'b0, 1'b0);

    // single beat
    cyc(1, 4'hA, 1'b1, 1'b1, 1'b1);
    cyc(0, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc(0, 4'h0, 1'b0, 1'b0, 1'b1);

    // fill to full, refuse a fifth beat, then drain in order
    for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 1'b0, 1'b1, 1'b0);
    cyc(1, 4'h5, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(0, 4'h0, 1'b0, 1'b0, 1'b1);

    // steady concurrent traffic at count 2 across pointer wrap
    cyc(1, 4'h1, 1'b0, 1'b1, 1'b0);
    cyc(1, 4'h2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1, 4'(i + 3), 1'(i), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(0, 4'h0, 1'b0, 1'b0, 1'b1);

    // reset with a partial packet buffered
    for (int i = 0; i < 3; i++) cyc(1, 4'(i + 8), 1'b1, 1'b0, 1'b0);
    do_reset();
    cyc(1, 4'h7, 1'b0, 1'b1, 1'b1);
    cyc(0, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc(0, 4'h0, 1'b0, 1'b0, 1'b1);

    // packet held until its last beat, then a 6-beat packet longer than DEPTH
    cyc(1, 4'h1, 1'b0, 1'b0, 1'b0);
    cyc(1, 4'h2, 1'b0, 1'b0, 1'b0);
    cyc(1, 4'h3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(0, 4'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) cyc(1, 4'(i), 1'b1, 1'(i == 6), 1'b1);
    for (int i = 0; i < 6; i++) cyc(0, 4'h0, 1'b0, 1'b0, 1'b1);

    // back-pressure hold with writes continuing
    cyc(1, 4'hC, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1, 4'(i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(0, 4'h0, 1'b0, 1'b0, 1'b1);

    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 8; i++) cyc(0, 4'h0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
